// File: rtl/edge_bbox_tracker.sv
// Edge-pixel bounding-box tracker: counts edge pixels per frame, latches their bounding box
// at each frame end and overlays the previous frame's box on the 1-cycle-delayed video.
module edge_bbox_tracker #(
   parameter int LINE_WIDTH   = 640,
   parameter int FRAME_HEIGHT = 480,
   parameter int PIXEL_DEPTH  = 8,
   parameter int MIN_EDGES    = 64,
   parameter logic [3*PIXEL_DEPTH-1:0] BOX_COLOR = 24'h00FF00,
   localparam int XW = $clog2(LINE_WIDTH),
   localparam int YW = $clog2(FRAME_HEIGHT),
   localparam int CW = $clog2(LINE_WIDTH*FRAME_HEIGHT+1)
) (
   input  logic                   clk,
   input  logic                   rst_ni,
   input  logic                   en_i,
   input  logic                   vs_ni,
   input  logic                   hs_ni,
   input  logic                   blank_ni,
   input  logic [PIXEL_DEPTH-1:0] input_R,
   input  logic [PIXEL_DEPTH-1:0] input_G,
   input  logic [PIXEL_DEPTH-1:0] input_B,
   output logic                   vs_no,
   output logic                   hs_no,
   output logic                   blank_no,
   output logic [PIXEL_DEPTH-1:0] output_R,
   output logic [PIXEL_DEPTH-1:0] output_G,
   output logic [PIXEL_DEPTH-1:0] output_B,
   output logic [XW-1:0]          x_min,
   output logic [XW-1:0]          x_max,
   output logic [YW-1:0]          y_min,
   output logic [YW-1:0]          y_max,
   output logic [CW-1:0]          edge_count,
   output logic                   bbox_valid,
   output logic                   frame_done
);

   typedef enum logic [1:0] {WAIT_VS, ACTIVE, LATCH} state_t;

   state_t state_q, state_d;

   logic                   vs_p1, hs_p1, blank_p1;
   logic [PIXEL_DEPTH-1:0] r_p1, g_p1, b_p1;
   logic [XW-1:0]          x_p0;
   logic [YW-1:0]          y_p0;

   logic [CW-1:0] acc_cnt_q, acc_cnt_d, cnt_b;
   logic [XW-1:0] acc_x_min_q, acc_x_max_q, acc_x_min_d, acc_x_max_d, x_min_b, x_max_b;
   logic [YW-1:0] acc_y_min_q, acc_y_max_q, acc_y_min_d, acc_y_max_d, y_min_b, y_max_b;

   logic edge_px, vs_fall, blank_fall, clr, take, publish, on_col, on_row, paint;

   function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] v);
      return (v == XW'(LINE_WIDTH - 1)) ? v : v + XW'(1);
   endfunction

   function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
      return (v == YW'(FRAME_HEIGHT - 1)) ? v : v + YW'(1);
   endfunction

   function automatic logic [CW-1:0] sat_inc_cnt(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + CW'(1);
   endfunction

   // The delayed sync/blank double as the previous sample for edge detection
   assign edge_px    = blank_ni & (input_R[PIXEL_DEPTH-1] | input_G[PIXEL_DEPTH-1] | input_B[PIXEL_DEPTH-1]);
   assign vs_fall    = vs_p1 & ~vs_ni;
   assign blank_fall = blank_p1 & ~blank_ni;

   // stage p0: pixel position of the current input sample
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         x_p0 <= '0;
         y_p0 <= '0;
      end else if (en_i) begin
         if (vs_fall) begin
            x_p0 <= '0;
            y_p0 <= '0;
         end else if (blank_fall) begin
            x_p0 <= '0;
            y_p0 <= sat_inc_y(y_p0);
         end else if (blank_ni) begin
            x_p0 <= sat_inc_x(x_p0);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      clr     = 1'b0;
      take    = 1'b0;
      publish = 1'b0;
      case (state_q)
         WAIT_VS: if (vs_fall) begin
            state_d = ACTIVE;
            clr     = 1'b1;
         end
         ACTIVE: begin
            take = edge_px;
            if (vs_fall) state_d = LATCH;
         end
         LATCH: begin
            publish = 1'b1;
            clr     = 1'b1;
            take    = edge_px;
            state_d = ACTIVE;
         end
         default: state_d = WAIT_VS;
      endcase
   end

   // A pixel arriving during LATCH is the first of the new frame
   always_comb begin
      cnt_b       = clr ? '0 : acc_cnt_q;
      x_min_b     = clr ? '0 : acc_x_min_q;
      x_max_b     = clr ? '0 : acc_x_max_q;
      y_min_b     = clr ? '0 : acc_y_min_q;
      y_max_b     = clr ? '0 : acc_y_max_q;
      acc_cnt_d   = cnt_b;
      acc_x_min_d = x_min_b;
      acc_x_max_d = x_max_b;
      acc_y_min_d = y_min_b;
      acc_y_max_d = y_max_b;
      if (take) begin
         acc_cnt_d = sat_inc_cnt(cnt_b);
         if (cnt_b == '0) begin
            acc_x_min_d = x_p0;
            acc_x_max_d = x_p0;
            acc_y_min_d = y_p0;
            acc_y_max_d = y_p0;
         end else begin
            if (x_p0 < x_min_b) acc_x_min_d = x_p0;
            if (x_p0 > x_max_b) acc_x_max_d = x_p0;
            if (y_p0 < y_min_b) acc_y_min_d = y_p0;
            if (y_p0 > y_max_b) acc_y_max_d = y_p0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= WAIT_VS;
         acc_cnt_q   <= '0;
         acc_x_min_q <= '0;
         acc_x_max_q <= '0;
         acc_y_min_q <= '0;
         acc_y_max_q <= '0;
      end else if (en_i) begin
         state_q     <= state_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_x_min_q <= acc_x_min_d;
         acc_x_max_q <= acc_x_max_d;
         acc_y_min_q <= acc_y_min_d;
         acc_y_max_q <= acc_y_max_d;
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         x_min      <= '0;
         x_max      <= '0;
         y_min      <= '0;
         y_max      <= '0;
         edge_count <= '0;
         bbox_valid <= 1'b0;
         frame_done <= 1'b0;
      end else if (en_i) begin
         frame_done <= publish;
         if (publish) begin
            x_min      <= acc_x_min_q;
            x_max      <= acc_x_max_q;
            y_min      <= acc_y_min_q;
            y_max      <= acc_y_max_q;
            edge_count <= acc_cnt_q;
            bbox_valid <= (acc_cnt_q >= CW'(MIN_EDGES));
         end
      end
   end

   assign on_col = ((x_p0 == x_min) || (x_p0 == x_max)) && (y_p0 >= y_min) && (y_p0 <= y_max);
   assign on_row = ((y_p0 == y_min) || (y_p0 == y_max)) && (x_p0 >= x_min) && (x_p0 <= x_max);
   assign paint  = bbox_valid & blank_ni & (on_col | on_row);

   // stage p1: video re-emitted one enabled cycle late
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         vs_p1    <= 1'b1;
         hs_p1    <= 1'b1;
         blank_p1 <= 1'b1;
         r_p1     <= '0;
         g_p1     <= '0;
         b_p1     <= '0;
      end else if (en_i) begin
         vs_p1    <= vs_ni;
         hs_p1    <= hs_ni;
         blank_p1 <= blank_ni;
         {r_p1, g_p1, b_p1} <= paint ? BOX_COLOR : {input_R, input_G, input_B};
      end
   end

   assign vs_no    = vs_p1;
   assign hs_no    = hs_p1;
   assign blank_no = blank_p1;
   assign output_R = r_p1;
   assign output_G = g_p1;
   assign output_B = b_p1;

endmodule

// File: tb/tb_edge_bbox_tracker.sv
// Scoreboard bench for edge_bbox_tracker: a frame-level model predicts the delayed video and the
// per-frame statistics; a monitor compares them against the DUT on every enabled cycle.
module tb_edge_bbox_tracker;

   localparam int LW   = 32;
   localparam int FH   = 24;
   localparam int PD   = 8;
   localparam int MINE = 64;
   localparam int VB   = 3;
   localparam int HB   = 4;
   localparam logic [23:0] BOX = 24'h00FF00;
   localparam int XW = $clog2(LW);
   localparam int YW = $clog2(FH);
   localparam int CW = $clog2(LW*FH+1);

   typedef struct {
      int xmin; int xmax; int ymin; int ymax; int cnt; bit valid;
   } stat_t;

   logic clk = 1'b0;
   logic rst_ni = 1'b1;
   logic en_i = 1'b0;
   logic vs_ni = 1'b1, hs_ni = 1'b1, blank_ni = 1'b0;
   logic [PD-1:0] input_R = '0, input_G = '0, input_B = '0;
   logic vs_no, hs_no, blank_no;
   logic [PD-1:0] output_R, output_G, output_B;
   logic [XW-1:0] x_min, x_max;
   logic [YW-1:0] y_min, y_max;
   logic [CW-1:0] edge_count;
   logic bbox_valid, frame_done;

   int total = 0;
   int bad = 0;

   logic [26:0] sb_vid[$];
   stat_t       sb_stat[$];
   logic [26:0] last_exp;
   localparam logic [26:0] RST_VID = {3'b111, 24'h0};

   int    m_falls;
   bit    m_prev_vs;
   stat_t m_box;
   int    fx[$];
   int    fy[$];
   bit    emap [FH][LW];

   edge_bbox_tracker #(
      .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .PIXEL_DEPTH(PD), .MIN_EDGES(MINE), .BOX_COLOR(BOX)
   ) dut (
      .clk(clk), .rst_ni(rst_ni), .en_i(en_i),
      .vs_ni(vs_ni), .hs_ni(hs_ni), .blank_ni(blank_ni),
      .input_R(input_R), .input_G(input_G), .input_B(input_B),
      .vs_no(vs_no), .hs_no(hs_no), .blank_no(blank_no),
      .output_R(output_R), .output_G(output_G), .output_B(output_B),
      .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
      .edge_count(edge_count), .bbox_valid(bbox_valid), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [23:0] edge_rgb();
      logic [2:0] c;
      c = 3'($urandom_range(1, 7));
      return {c[2] ? 8'hFF : 8'h00, c[1] ? 8'hFF : 8'h00, c[0] ? 8'hFF : 8'h00};
   endfunction

   function automatic void model_reset();
      m_falls   = 0;
      m_prev_vs = 1'b1;
      m_box     = '{default: 0};
      fx.delete();
      fy.delete();
   endfunction

   // Close the frame: count and bounding box straight from the recorded edge coordinates
   function automatic void model_latch();
      stat_t s;
      s = '{default: 0};
      s.cnt = fx.size();
      if (s.cnt > 0) begin
         s.xmin = LW; s.xmax = -1; s.ymin = FH; s.ymax = -1;
         foreach (fx[i]) begin
            if (fx[i] < s.xmin) s.xmin = fx[i];
            if (fx[i] > s.xmax) s.xmax = fx[i];
            if (fy[i] < s.ymin) s.ymin = fy[i];
            if (fy[i] > s.ymax) s.ymax = fy[i];
         end
      end
      s.valid = (s.cnt >= MINE);
      sb_stat.push_back(s);
      m_box = s;
   endfunction

   function automatic void model_step(input bit vs, input bit hs, input bit bl,
                                      input logic [23:0] rgb, input int px, input int py);
      bit edge_px, fall, on_box;
      edge_px = bl && (rgb[23] || rgb[15] || rgb[7]);
      on_box  = m_box.valid &&
                (((px == m_box.xmin || px == m_box.xmax) && py >= m_box.ymin && py <= m_box.ymax) ||
                 ((py == m_box.ymin || py == m_box.ymax) && px >= m_box.xmin && px <= m_box.xmax));
      sb_vid.push_back({vs, hs, bl, (bl && on_box) ? BOX : rgb});
      fall = m_prev_vs && !vs;
      m_prev_vs = vs;
      if (m_falls > 0 && edge_px) begin
         fx.push_back(px);
         fy.push_back(py);
      end
      if (fall) begin
         if (m_falls > 0) model_latch();
         m_falls++;
         fx.delete();
         fy.delete();
      end
   endfunction

   task automatic do_reset();
      rst_ni = 1'b0;
      en_i   = 1'b0;
      #1;
      chk("rst_video", 32'({vs_no, hs_no, blank_no, output_R, output_G, output_B}), 32'(RST_VID));
      chk("rst_x_min", 32'(x_min), 0);
      chk("rst_x_max", 32'(x_max), 0);
      chk("rst_y_min", 32'(y_min), 0);
      chk("rst_y_max", 32'(y_max), 0);
      chk("rst_edge_count", 32'(edge_count), 0);
      chk("rst_bbox_valid", 32'(bbox_valid), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      model_reset();
      sb_stat.delete();
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;
   endtask

   task automatic beat(input bit vs, input bit hs, input bit bl, input logic [23:0] rgb,
                       input int px, input int py, input bit stall);
      while (stall && $urandom_range(0, 1) == 1) begin
         en_i = 1'b0;
         vs_ni = 1'($urandom); hs_ni = 1'($urandom); blank_ni = 1'($urandom);
         {input_R, input_G, input_B} = 24'($urandom);
         @(negedge clk);
      end
      en_i = 1'b1;
      vs_ni = vs; hs_ni = hs; blank_ni = bl;
      {input_R, input_G, input_B} = rgb;
      model_step(vs, hs, bl, rgb, px, py);
      @(negedge clk);
   endtask

   // Random frames overrun both the line and the frame to exercise position saturation
   task automatic frame(input bit rnd, input bit stall, input int abort_line);
      int nl, np;
      logic [23:0] rgb;
      nl = rnd ? FH + 2 : FH;
      np = rnd ? LW + 2 : LW;
      for (int v = 0; v < VB; v++)
         for (int h = 0; h < LW + HB; h++)
            beat(v != 0, h < LW + HB - 2, 1'b0, 24'($urandom), -1, -1, stall);
      for (int y = 0; y < nl; y++) begin
         if (y == abort_line) begin
            do_reset();
            return;
         end
         for (int h = 0; h < np + HB; h++) begin
            if (h < np) begin
               if (rnd) begin
                  rgb = 24'($urandom) & 24'h7F7F7F;
                  if ($urandom_range(0, 99) < 3) rgb = rgb | edge_rgb();
               end else begin
                  rgb = emap[y][h] ? edge_rgb() : 24'h0;
               end
               beat(1'b1, h < np + HB - 2, 1'b1, rgb, (h < LW) ? h : LW - 1, (y < FH) ? y : FH - 1, stall);
            end else begin
               beat(1'b1, h < np + HB - 2, 1'b0, 24'($urandom), -1, -1, stall);
            end
         end
      end
   endtask

   task automatic clear_map();
      foreach (emap[y, x]) emap[y][x] = 1'b0;
   endtask

   task automatic rect_map(input int x0, input int x1, input int y0, input int y1);
      clear_map();
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++) emap[y][x] = 1'b1;
   endtask

   task automatic few_map(input int n);
      int placed, x, y;
      clear_map();
      placed = 0;
      while (placed < n) begin
         x = $urandom_range(0, LW - 1);
         y = $urandom_range(0, FH - 1);
         if (!emap[y][x]) begin
            emap[y][x] = 1'b1;
            placed++;
         end
      end
   endtask

   // Monitor: pops one expected beat per enabled edge, and one stats record per frame_done
   initial begin
      logic en_s, rs_s;
      stat_t e;
      last_exp = RST_VID;
      forever begin
         @(posedge clk);
         en_s = en_i;
         rs_s = rst_ni;
         #1;
         if (!rs_s || !rst_ni) begin
            last_exp = RST_VID;
         end else begin
            if (en_s) begin
               if (sb_vid.size() == 0) begin
                  total++; bad++;
                  $display("FAIL video_queue: DUT advanced with no expected beat at %0t", $time);
               end else begin
                  last_exp = sb_vid.pop_front();
               end
            end
            chk("video", 32'({vs_no, hs_no, blank_no, output_R, output_G, output_B}), 32'(last_exp));
            if (en_s && frame_done) begin
               if (sb_stat.size() == 0) begin
                  total++; bad++;
                  $display("FAIL frame_done: unexpected pulse, edge_count=%0d at %0t", edge_count, $time);
               end else begin
                  e = sb_stat.pop_front();
                  chk("x_min", 32'(x_min), e.xmin);
                  chk("x_max", 32'(x_max), e.xmax);
                  chk("y_min", 32'(y_min), e.ymin);
                  chk("y_max", 32'(y_max), e.ymax);
                  chk("edge_count", 32'(edge_count), e.cnt);
                  chk("bbox_valid", 32'(bbox_valid), 32'(e.valid));
               end
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time bound");
      $fatal(1);
   end

   initial begin
      model_reset();
      #2;
      do_reset();
      clear_map();
      frame(1'b0, 1'b0, -1);
      frame(1'b0, 1'b0, -1);
      rect_map(10, 19, 5, 14);
      frame(1'b0, 1'b0, -1);
      clear_map();
      frame(1'b0, 1'b0, -1);
      few_map(63);
      frame(1'b0, 1'b0, -1);
      frame(1'b1, 1'b0, -1);
      rect_map(10, 19, 5, 14);
      frame(1'b0, 1'b1, -1);
      frame(1'b1, 1'b1, -1);
      few_map(64);
      frame(1'b0, 1'b0, -1);
      frame(1'b1, 1'b0, -1);
      frame(1'b1, 1'b0, 12);
      rect_map(3, 28, 0, 23);
      frame(1'b0, 1'b0, -1);
      frame(1'b1, 1'b1, -1);
      clear_map();
      frame(1'b0, 1'b0, -1);
      en_i = 1'b0;
      repeat (10) @(negedge clk);
      chk("stats_drained", 32'(sb_stat.size()), 0);
      chk("video_drained", 32'(sb_vid.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
